// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : if_fetch_stage_pkg
//  Description : Shared widths, the NOP encoding and the fetch FSM state
//                encodings for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_stage_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;

  localparam logic [INSTRUCTION_LEN-1:0] NOP_INSTRUCTION = 32'b0;

  // REQ   : fetch outstanding at pc
  // HOLD  : response captured while decode is frozen, no request
  // DRAIN : wrong-path fetch still outstanding, redirect target parked
  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_reg
//  Description : IF/ID pipeline register. flush loads a bubble (PC kept,
//                NOP, valid=0), load copies the inputs, otherwise holds.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst (async, active-high)
//                i_load, i_flush          - register control (flush wins)
//                i_pc, i_instr, i_valid   - next IF/ID contents
//                o_pc, o_instr, o_valid   - registered IF/ID contents
// ============================================================================
module if_stage_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int INSTR_W = INSTRUCTION_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pc    <= '0;
      o_instr <= INSTR_W'(NOP_INSTRUCTION);
      o_valid <= 1'b0;
    end else if (i_flush) begin
      // Bubble keeps the last PC so decode sees a stable PC field.
      o_instr <= INSTR_W'(NOP_INSTRUCTION);
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_pc    <= i_pc;
      o_instr <= i_instr;
      o_valid <= i_valid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage. Owns the PC and the IF/ID register,
//                fetches over a req/ready instruction-memory handshake,
//                honours the hazard freeze and redirects on branch_taken.
//  Revision    : 1.0 - initial release
//  Macro       : IF_FETCH_COUNT_EN - builds the delivered-instruction counter;
//                when undefined fetched_count is tied to 0.
//  Ports       : clk, rst (async, active-high)
//                freeze, branch_taken, branch_address - pipeline control
//                imem_req, imem_addr, imem_ready, imem_rdata - memory port
//                PC_out, Instruction_out, valid_out - IF/ID register
//                fetched_count - delivered-instruction count
// ============================================================================
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = ADDRESS_LEN,
  parameter int                INSTR_W  = INSTRUCTION_LEN,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] Instruction_out,
  output logic               valid_out,
  output logic [31:0]        fetched_count
);

  if_state_e          r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_target;
  logic [INSTR_W-1:0] r_hold_buf;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic [INSTR_W-1:0] w_ld_instr;
  logic               w_load;
  logic               w_flush;

  // Request is dropped only in HOLD; DRAIN keeps the old address up until
  // the wrong-path response arrives.
  assign imem_req  = ~rst & (r_state != IF_HOLD);
  assign imem_addr = r_pc;
  assign w_pc_inc  = r_pc + ADDR_W'(4);

  always_comb begin
    w_ld_instr = (r_state == IF_HOLD) ? r_hold_buf : imem_rdata;
    // A bubble enters on any redirect, during a drain, and while an
    // unfrozen fetch is still waiting.
    w_flush = branch_taken
            | (r_state == IF_DRAIN)
            | ((r_state == IF_REQ) & ~imem_ready & ~freeze);
    w_load  = ~branch_taken & ~freeze
            & (((r_state == IF_REQ) & imem_ready) | (r_state == IF_HOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IF_REQ;
      r_pc       <= RESET_PC;
      r_target   <= '0;
      r_hold_buf <= '0;
    end else begin
      case (r_state)
        IF_REQ: begin
          if (branch_taken) begin
            if (imem_ready) begin
              r_pc <= branch_address;
            end else begin
              r_target <= branch_address;
              r_state  <= IF_DRAIN;
            end
          end else if (imem_ready) begin
            if (freeze) begin
              r_hold_buf <= imem_rdata;
              r_state    <= IF_HOLD;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        IF_HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_address;
            r_state <= IF_REQ;
          end else if (!freeze) begin
            r_pc    <= w_pc_inc;
            r_state <= IF_REQ;
          end
        end
        IF_DRAIN: begin
          // A branch arriving on the drain edge is the latest one and wins.
          if (imem_ready) begin
            r_pc    <= branch_taken ? branch_address : r_target;
            r_state <= IF_REQ;
          end else if (branch_taken) begin
            r_target <= branch_address;
          end
        end
        default: r_state <= IF_REQ;
      endcase
    end
  end

  if_stage_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_pc    (w_pc_inc),
    .i_instr (w_ld_instr),
    .i_valid (1'b1),
    .o_pc    (PC_out),
    .o_instr (Instruction_out),
    .o_valid (valid_out)
  );

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] r_fetched_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetched_count <= 32'd0;
    end else if (w_load) begin
      r_fetched_count <= r_fetched_count + 32'd1;
    end
  end

  assign fetched_count = r_fetched_count;
`else
  assign fetched_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Self-checking bench for if_fetch_stage: a vector table of
//                per-cycle stimulus/expectations, a mid-HOLD reset sequence
//                and a random wait-state/freeze stream with a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] E = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        valid_out;
  logic [31:0] fetched_count;

  always #5 clk = ~clk;

  // Memory model: instruction word encodes its own address.
  always_comb imem_rdata = E | imem_addr;

  if_fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .valid_out       (valid_out),
    .fetched_count   (fetched_count)
  );

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ev;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  logic [63:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef IF_FETCH_COUNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic rd, input logic eq, input logic [31:0] ea,
                     input logic [31:0] ep, input logic [31:0] ei, input logic ev);
    vec_t v;
    v = '{rst:r, frz:f, br:b, baddr:ba, rdy:rd, ereq:eq, eaddr:ea, epc:ep, einstr:ei, ev:ev};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        e;
    logic [63:0] s;
    logic [31:0] m_addr;
    logic        m_hold;
    logic        f;

    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    branch_address = '0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req},  32'd0);
    chk("rst_addr",  imem_addr,          32'd0);
    chk("rst_pc",    PC_out,             32'd0);
    chk("rst_instr", Instruction_out,    32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_cnt",   fetched_count,      32'd0);
    rst = 1'b0;

    //   rst frz br baddr        rdy req addr         PC_out      instr          v
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,        32'h4,      E,             1);
    add(0, 0, 0, 32'h0,        1,  1, 32'h4,        32'h8,      E|32'h4,       1);
    add(0, 0, 0, 32'h0,        1,  1, 32'h8,        32'hC,      E|32'h8,       1);
    add(1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,      32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,        32'h4,      E,             1);
    add(0, 0, 0, 32'h0,        1,  1, 32'h4,        32'h8,      E|32'h4,       1);
    add(0, 0, 0, 32'h0,        0,  1, 32'h8,        32'h8,      32'h0,         0);
    add(0, 0, 0, 32'h0,        0,  1, 32'h8,        32'h8,      32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h8,        32'hC,      E|32'h8,       1);
    add(1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h0,      32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,        32'h4,      E,             1);
    add(0, 1, 0, 32'h0,        1,  1, 32'h4,        32'h4,      E,             1);
    add(0, 1, 0, 32'h0,        1,  0, 32'h4,        32'h4,      E,             1);
    add(0, 1, 0, 32'h0,        1,  0, 32'h4,        32'h4,      E,             1);
    add(0, 0, 0, 32'h0,        1,  0, 32'h4,        32'h8,      E|32'h4,       1);
    add(0, 0, 0, 32'h0,        0,  1, 32'h8,        32'h8,      32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h8,        32'hC,      E|32'h8,       1);
    add(0, 0, 0, 32'h0,        1,  1, 32'hC,        32'h10,     E|32'hC,       1);
    add(0, 0, 1, 32'h100,      1,  1, 32'h10,       32'h10,     32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h100,      32'h104,    E|32'h100,     1);
    add(0, 0, 1, 32'h20,       1,  1, 32'h104,      32'h104,    32'h0,         0);
    add(0, 0, 1, 32'h80,       0,  1, 32'h20,       32'h104,    32'h0,         0);
    add(0, 0, 0, 32'h0,        0,  1, 32'h20,       32'h104,    32'h0,         0);
    add(0, 0, 1, 32'h90,       0,  1, 32'h20,       32'h104,    32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h20,       32'h104,    32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h90,       32'h94,     E|32'h90,      1);
    add(0, 1, 0, 32'h0,        1,  1, 32'h94,       32'h94,     E|32'h90,      1);
    add(0, 1, 1, 32'h200,      0,  0, 32'h94,       32'h94,     32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h200,      32'h204,    E|32'h200,     1);
    add(0, 0, 1, 32'hFFFFFFFC, 0,  1, 32'h204,      32'h204,    32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'h204,      32'h204,    32'h0,         0);
    add(0, 0, 0, 32'h0,        1,  1, 32'hFFFFFFFC, 32'h0,      32'hFFFFFFFC,  1);
    add(0, 0, 0, 32'h0,        1,  1, 32'h0,        32'h4,      E,             1);
    add(0, 1, 0, 32'h0,        0,  1, 32'h4,        32'h4,      E,             1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst            = tbl[i].rst;
      freeze         = tbl[i].frz;
      branch_taken   = tbl[i].br;
      branch_address = tbl[i].baddr;
      imem_ready     = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].ereq});
      if (tbl[i].ereq || tbl[i].rst)
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.rst) exp_cnt = 32'd0;
      else if (e.ev && !e.frz) exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("v%0d_pc", i),    PC_out,             e.epc);
      chk($sformatf("v%0d_instr", i), Instruction_out,    e.einstr);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_out}, {31'd0, e.ev});
      chk($sformatf("v%0d_cnt", i),   fetched_count,      cnt_exp());
    end

    // Reset asserted mid-HOLD must clear the outputs before any clock edge.
    rst = 1'b0; freeze = 1'b1; branch_taken = 1'b0; imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    exp_cnt = 32'd0;
    chk("arst_req",   {31'd0, imem_req},  32'd0);
    chk("arst_addr",  imem_addr,          32'd0);
    chk("arst_pc",    PC_out,             32'd0);
    chk("arst_instr", Instruction_out,    32'd0);
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    chk("arst_cnt",   fetched_count,      cnt_exp());
    @(posedge clk);
    #1;
    rst = 1'b0; freeze = 1'b0; imem_ready = 1'b0;
    #1;
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr,         32'd0);

    // Random wait states and freezes, no branches: every accepted response
    // must be delivered once, in order.
    @(posedge clk);
    #1;
    m_addr = 32'd0;
    m_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      f          = (c < 396) && ($urandom_range(0, 3) == 0);
      freeze     = f;
      imem_ready = (c >= 396) || ($urandom_range(0, 1) == 1);
      #1;
      chk("sb_req", {31'd0, imem_req}, {31'd0, ~m_hold});
      if (!m_hold) begin
        chk("sb_addr", imem_addr, m_addr);
        if (imem_ready) begin
          sb_q.push_back({m_addr + 32'd4, E | m_addr});
          m_addr = m_addr + 32'd4;
          m_hold = f;
        end
      end else if (!f) begin
        m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!f && valid_out) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          s = sb_q.pop_front();
          exp_cnt = exp_cnt + 32'd1;
          chk("sb_pc",    PC_out,          s[63:32]);
          chk("sb_instr", Instruction_out, s[31:0]);
        end
      end
    end
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("sb_cnt",     fetched_count, cnt_exp());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage; owns the program counter and the IF/ID pipeline register.
- Issues fetches to an external instruction memory through a req/ready handshake with variable wait states.
- Delivers {PC+4, instruction, valid} to decode; obeys the hazard freeze and redirects on branch_taken from execute.

Parameters:
ADDR_W, 32, PC/address width (matches ADDRESS_LEN)
INSTR_W, 32, instruction width (matches INSTRUCTION_LEN)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  hazard stall from the hazard unit; hold PC and the IF/ID register
branch_taken  in  1  redirect request from execute; also flushes the IF/ID register
branch_address  in  ADDR_W  redirect target, valid with branch_taken
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  fetch completes on a rising edge where imem_req&imem_ready
imem_rdata  in  INSTR_W  instruction, valid when imem_ready=1
PC_out  out  ADDR_W  IF/ID register: fetched PC+4
Instruction_out  out  INSTR_W  IF/ID register: instruction (NOP when bubble)
valid_out  out  1  IF/ID register: 1 = real instruction
fetched_count  out  32  delivered-instruction counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC, state=REQ, hold buffer cleared, target=0, PC_out=0, Instruction_out=NOP(0), valid_out=0, fetched_count=0. imem_req is gated low while rst=1.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: instruction captured, decode frozen; imem_req=0.
  - DRAIN: wrong-path fetch outstanding; imem_req=1, imem_addr=pc (old); the redirect target is held in the target register.
- Priority per edge: rst > branch_taken > freeze > normal.
- REQ, handshake completes (ready=1):
  - freeze=0: IF/ID <= {pc+4, rdata, 1}; pc <= pc+4. Zero-wait memory gives 1 instruction/cycle.
  - freeze=1: hold_buf <= rdata; go to HOLD; pc and IF/ID unchanged.
- REQ, ready=0: stay in REQ; address stable; IF/ID loads a bubble {PC_out unchanged, NOP, 0} if freeze=0, else holds.
- HOLD, freeze=0: IF/ID <= {pc+4, hold_buf, 1}; pc <= pc+4; go to REQ. HOLD, freeze=1: stay.
- branch_taken (any state, overrides freeze):
  - IF/ID <= bubble {PC_out unchanged, NOP, 0}.
  - REQ with ready=1: response discarded; pc <= branch_address; stay in REQ.
  - REQ with ready=0: target <= branch_address; go to DRAIN.
  - HOLD: hold_buf discarded; pc <= branch_address; go to REQ.
  - DRAIN: target <= branch_address; the latest branch wins.
- DRAIN, ready=1: data discarded; pc <= target; go to REQ. No wrong-path instruction ever reaches valid_out=1.
- freeze=1 with no branch: IF/ID register and pc hold, with the REQ-state handshake exceptions above.
- pc arithmetic is modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0 is silent.
- Mid-operation reset clears everything immediately; a pending memory response after reset release is not expected (the memory is reset by the same rst).

Optional Feature:
- Macro: IF_FETCH_COUNT_EN.
- Defined: fetched_count increments by 1 on every edge where valid_out is loaded with 1. It wraps at 2^32, resets to 0, and is unaffected by freeze and bubbles.
- Undefined: no counter register is built; fetched_count is tied to 0.

Decomposition:
- Shared defines package: ADDRESS_LEN, INSTRUCTION_LEN, NOP_INSTRUCTION (32'b0), IF state encodings (REQ, HOLD, DRAIN; 2 bits).
- One sub-module, if_stage_reg: the IF/ID register. It takes clk, rst, load, flush and {PC, instruction, valid}. flush loads a bubble, load copies its inputs, otherwise it holds.
- The FSM, pc/target/hold_buf and counter stay in if_fetch_stage.

Test Plan:
- Reset released, imem_ready=1, rdata=0xE0000000|addr -> PC_out 4, 8, 12 on consecutive cycles; Instruction_out 0xE0000000, 0xE0000004, 0xE0000008; valid_out=1; fetched_count=3.
- Wait states: ready=0 for 2 cycles at pc=8 -> imem_addr stays 8, valid_out=0 for 2 cycles, then PC_out=12 with Instruction_out=0xE0000008.
- freeze=1 for 3 cycles while pc=4 is fetched with ready=1 -> imem_req=0 in HOLD, IF/ID holds the previous value; after freeze drops, PC_out=8 appears exactly once and the next imem_addr=8.
- branch_taken to 0x100 while fetching 0x10 with ready=1 -> valid_out=0 on the next edge, next imem_addr=0x100, then PC_out=0x104.
- branch_taken to 0x80 while the fetch of 0x20 waits (ready=0), a second branch to 0x90 in DRAIN, ready=1 two cycles later -> imem_addr=0x20 until ready, no valid_out for 0x20, next imem_addr=0x90.
- rst pulsed mid-HOLD -> outputs 0, valid_out=0, imem_req=0 immediately; after release, imem_addr=RESET_PC.
